// File: rtl/signed_division_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : signed_division_sequencer
// Description : Signed front/back end for an unsigned divider. Handles operand
//               magnitudes, truncating sign correction, div-by-zero and timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module signed_division_sequencer #(
  parameter int WIDTH   = 12,
  parameter int TIMEOUT = 64
) (
  input  logic             aclk,
  input  logic             resetn,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_numerator,
  input  logic [WIDTH-1:0] s_denominator,
  output logic [WIDTH-1:0] div_numerator,
  output logic [WIDTH-1:0] div_denominator,
  output logic             div_data_valid,
  input  logic [WIDTH-1:0] div_quotient,
  input  logic [WIDTH-1:0] div_remainder,
  input  logic             div_data_ready,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_quotient,
  output logic [WIDTH-1:0] m_remainder,
  output logic             m_div0,
  output logic             m_overflow,
  output logic             m_timeout
);

  localparam int               c_CNT_W = $clog2(TIMEOUT) + 1;
  localparam logic [WIDTH-1:0] c_MIN   = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] c_MAX   = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] c_ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [c_CNT_W-1:0] c_LAST    = c_CNT_W'(TIMEOUT - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic               r_alive;
  logic               r_num_neg;
  logic               r_den_neg;
  logic [WIDTH-1:0]   r_num_mag;
  logic [WIDTH-1:0]   r_den_mag;
  logic [c_CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0]   r_q;
  logic [WIDTH-1:0]   r_r;
  logic               r_div0;
  logic               r_ovf;
  logic               r_tmo;

  logic               w_accept;
  logic               w_num_neg;
  logic               w_den_neg;
  logic [WIDTH-1:0]   w_num_mag;
  logic [WIDTH-1:0]   w_den_mag;
  logic               w_den_zero;
  logic               w_strobe;
  logic               w_expire;
  logic               w_q_neg;
  logic [WIDTH-1:0]   w_q_res;
  logic [WIDTH-1:0]   w_r_res;
  logic               w_ovf;

  // r_alive keeps s_ready low while in reset and for the release cycle
  assign s_ready        = r_alive && (r_state == ST_IDLE);
  assign div_data_valid = (r_state == ST_ISSUE);
  assign m_valid        = (r_state == ST_OUT);
  assign div_numerator  = r_num_mag;
  assign div_denominator = r_den_mag;
  assign m_quotient     = r_q;
  assign m_remainder    = r_r;
  assign m_div0         = r_div0;
  assign m_overflow     = r_ovf;
  assign m_timeout      = r_tmo;

  assign w_accept   = s_valid && s_ready;
  assign w_num_neg  = s_numerator[WIDTH-1];
  assign w_den_neg  = s_denominator[WIDTH-1];
  assign w_num_mag  = w_num_neg ? (~s_numerator + c_ONE) : s_numerator;
  assign w_den_mag  = w_den_neg ? (~s_denominator + c_ONE) : s_denominator;
  assign w_den_zero = (s_denominator == '0);

  assign w_strobe = (r_state == ST_WAIT) && div_data_ready;
  assign w_expire = (r_state == ST_WAIT) && !div_data_ready && (r_cnt == c_LAST);
  assign w_q_neg  = r_num_neg ^ r_den_neg;

  // A positive quotient of magnitude 2^(W-1) only arises from MIN / -1
  always_comb begin
    w_ovf   = 1'b0;
    w_q_res = div_quotient;
    if (!w_q_neg && (div_quotient == c_MIN)) begin
      w_ovf   = 1'b1;
      w_q_res = c_MAX;
    end else if (w_q_neg) begin
      w_q_res = ~div_quotient + c_ONE;
    end
  end

  assign w_r_res = r_num_neg ? (~div_remainder + c_ONE) : div_remainder;

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_next = w_den_zero ? ST_OUT : ST_ISSUE;
        end
      end
      ST_ISSUE: w_next = ST_WAIT;
      ST_WAIT: begin
        if (w_strobe || w_expire) begin
          w_next = ST_OUT;
        end
      end
      ST_OUT: begin
        if (m_ready) begin
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      r_alive   <= 1'b0;
      r_num_neg <= 1'b0;
      r_den_neg <= 1'b0;
      r_num_mag <= '0;
      r_den_mag <= '0;
      r_cnt     <= '0;
      r_q       <= '0;
      r_r       <= '0;
      r_div0    <= 1'b0;
      r_ovf     <= 1'b0;
      r_tmo     <= 1'b0;
    end else begin
      r_alive <= 1'b1;
      if (w_accept) begin
        r_num_neg <= w_num_neg;
        r_den_neg <= w_den_neg;
        r_num_mag <= w_num_mag;
        r_den_mag <= w_den_mag;
        r_div0    <= w_den_zero;
        r_ovf     <= 1'b0;
        r_tmo     <= 1'b0;
        if (w_den_zero) begin
          r_q <= w_num_neg ? c_MIN : c_MAX;
          r_r <= s_numerator;
        end
      end
      if (r_state == ST_ISSUE) begin
        r_cnt <= '0;
      end else if (r_state == ST_WAIT) begin
        r_cnt <= r_cnt + c_CNT_ONE;
      end
      if (w_strobe) begin
        r_q   <= w_q_res;
        r_r   <= w_r_res;
        r_ovf <= w_ovf;
      end else if (w_expire) begin
        r_tmo <= 1'b1;
        r_q   <= '0;
        r_r   <= '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_signed_division_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_signed_division_sequencer
// Description : Directed + random bench with an unsigned divider model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_signed_division_sequencer;

  localparam int W = 12;

  logic         aclk = 1'b0;
  logic         resetn = 1'b0;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [W-1:0] s_numerator = '0;
  logic [W-1:0] s_denominator = '0;
  logic [W-1:0] div_numerator;
  logic [W-1:0] div_denominator;
  logic         div_data_valid;
  logic [W-1:0] div_quotient = '0;
  logic [W-1:0] div_remainder = '0;
  logic         div_data_ready = 1'b0;
  logic         m_valid;
  logic         m_ready = 1'b0;
  logic [W-1:0] m_quotient;
  logic [W-1:0] m_remainder;
  logic         m_div0;
  logic         m_overflow;
  logic         m_timeout;

  int n_cmp = 0;
  int n_bad = 0;

  signed_division_sequencer #(.WIDTH(W), .TIMEOUT(64)) dut (
    .aclk(aclk), .resetn(resetn),
    .s_valid(s_valid), .s_ready(s_ready),
    .s_numerator(s_numerator), .s_denominator(s_denominator),
    .div_numerator(div_numerator), .div_denominator(div_denominator),
    .div_data_valid(div_data_valid),
    .div_quotient(div_quotient), .div_remainder(div_remainder),
    .div_data_ready(div_data_ready),
    .m_valid(m_valid), .m_ready(m_ready),
    .m_quotient(m_quotient), .m_remainder(m_remainder),
    .m_div0(m_div0), .m_overflow(m_overflow), .m_timeout(m_timeout)
  );

  always #5 aclk = ~aclk;

  // Unsigned divider model: WIDTH+2 cycle latency, not reset by resetn
  logic [W-1:0] mdl_a = '0;
  logic [W-1:0] mdl_b = '0;
  int           mdl_lat = 0;
  bit           mdl_busy = 1'b0;
  bit           mdl_never = 1'b0;

  always @(posedge aclk) begin
    div_data_ready <= 1'b0;
    if (mdl_busy) begin
      if (mdl_lat == 0) begin
        mdl_busy <= 1'b0;
        if (!mdl_never && mdl_b != '0) begin
          div_data_ready <= 1'b1;
          div_quotient   <= mdl_a / mdl_b;
          div_remainder  <= mdl_a % mdl_b;
        end
      end else begin
        mdl_lat <= mdl_lat - 1;
      end
    end else if (div_data_valid) begin
      mdl_busy <= 1'b1;
      mdl_lat  <= W + 2 - 2;
      mdl_a    <= div_numerator;
      mdl_b    <= div_denominator;
    end
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One full transaction: reference result from plain signed arithmetic
  task automatic run_op(input int n, input int d, input int hold, input bit tmo_exp);
    logic [W-1:0] eq, er, en_mag, ed_mag;
    logic         ediv0, eovf;
    int           q, r, lat, dv, first_dv, w;
    bit           prev_rdy;
    en_mag = W'(n < 0 ? -n : n);
    ed_mag = W'(d < 0 ? -d : d);
    ediv0  = 1'b0;
    eovf   = 1'b0;
    if (d == 0) begin
      ediv0 = 1'b1;
      eq    = (n >= 0) ? 12'h7ff : 12'h800;
      er    = W'(n);
    end else if (tmo_exp) begin
      eq = '0;
      er = '0;
    end else begin
      q = n / d;
      r = n % d;
      if (q > 2047) begin
        q    = 2047;
        eovf = 1'b1;
      end
      eq = W'(q);
      er = W'(r);
    end

    @(negedge aclk);
    w = 0;
    while (!s_ready && w < 20) begin
      @(negedge aclk);
      w++;
    end
    chk1("s_ready_idle", s_ready, 1'b1);
    s_valid       = 1'b1;
    s_numerator   = W'(n);
    s_denominator = W'(d);
    @(negedge aclk);
    s_valid  = 1'b0;
    dv       = 0;
    first_dv = 0;
    prev_rdy = 1'b0;
    for (lat = 1; lat <= 200; lat++) begin
      if (m_valid) break;
      chk1("s_ready_busy", s_ready, 1'b0);
      if (div_data_valid) begin
        dv++;
        if (first_dv == 0) first_dv = lat;
        chk("div_num", div_numerator, en_mag);
        chk("div_den", div_denominator, ed_mag);
      end
      if (div_data_ready) begin
        chk("div_num_held", div_numerator, en_mag);
        chk("div_den_held", div_denominator, ed_mag);
      end
      prev_rdy = div_data_ready;
      @(negedge aclk);
    end
    chk1("m_valid_arrives", m_valid, 1'b1);
    if (d == 0) begin
      chki("div0_latency", lat, 1);
      chki("div0_no_start", dv, 0);
    end else begin
      chki("start_pulses", dv, 1);
      chki("start_cycle", first_dv, 1);
      if (tmo_exp) chki("timeout_latency", lat, 66);
      else         chk1("result_after_strobe", prev_rdy, 1'b1);
    end

    for (int i = 0; i <= hold; i++) begin
      chk1("m_valid_hold", m_valid, 1'b1);
      chk1("s_ready_out", s_ready, 1'b0);
      chk("quotient", m_quotient, eq);
      chk("remainder", m_remainder, er);
      chk1("div0_flag", m_div0, ediv0);
      chk1("ovf_flag", m_overflow, eovf);
      chk1("tmo_flag", m_timeout, tmo_exp);
      if (i < hold) @(negedge aclk);
    end
    m_ready = 1'b1;
    @(negedge aclk);
    m_ready = 1'b0;
    chk1("m_valid_drop", m_valid, 1'b0);
    chk1("s_ready_after", s_ready, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n, d;
    bit  seen;
    repeat (3) @(negedge aclk);
    chk1("rst_s_ready", s_ready, 1'b0);
    chk1("rst_m_valid", m_valid, 1'b0);
    chk1("rst_div_valid", div_data_valid, 1'b0);
    chk("rst_quotient", m_quotient, '0);
    chk("rst_div_num", div_numerator, '0);
    resetn = 1'b1;
    @(negedge aclk);
    chk1("s_ready_after_release", s_ready, 1'b1);

    run_op(100, 7, 0, 1'b0);
    run_op(-100, 7, 0, 1'b0);
    run_op(100, -7, 0, 1'b0);
    run_op(-100, -7, 0, 1'b0);
    run_op(-2048, -1, 0, 1'b0);
    run_op(-2048, 1, 0, 1'b0);
    run_op(5, 0, 0, 1'b0);
    run_op(-5, 0, 0, 1'b0);
    run_op(1234, -37, 10, 1'b0);

    for (int k = 0; k < 30; k++) begin
      n = int'($urandom_range(0, 4095)) - 2048;
      d = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 4095)) - 2048;
      run_op(n, d, int'($urandom_range(0, 2)), 1'b0);
    end

    mdl_never = 1'b1;
    run_op(321, 4, 0, 1'b1);
    mdl_never = 1'b0;
    run_op(-77, 5, 0, 1'b0);

    // Reset while the divider is busy; its late strobe must be ignored
    @(negedge aclk);
    s_valid       = 1'b1;
    s_numerator   = W'(300);
    s_denominator = W'(9);
    @(negedge aclk);
    s_valid = 1'b0;
    repeat (4) @(negedge aclk);
    resetn = 1'b0;
    #1;
    chk1("mid_rst_m_valid", m_valid, 1'b0);
    chk1("mid_rst_s_ready", s_ready, 1'b0);
    chk1("mid_rst_div_valid", div_data_valid, 1'b0);
    chk("mid_rst_div_num", div_numerator, '0);
    chk("mid_rst_div_den", div_denominator, '0);
    chk("mid_rst_quotient", m_quotient, '0);
    chk("mid_rst_remainder", m_remainder, '0);
    chk1("mid_rst_timeout", m_timeout, 1'b0);
    repeat (2) @(negedge aclk);
    resetn = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge aclk);
      if (m_valid) seen = 1'b1;
    end
    chk1("late_strobe_ignored", seen, 1'b0);
    run_op(-1000, 3, 1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
